// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, opcodes, IR fields and class tables for the control unit
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    // Register-register ops writing their result back to ra
    function automatic logic is_three_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_three_op = 1'b1;
            default:                         is_three_op = 1'b0;
        endcase
    endfunction

    // Ops whose result lands in HI/LO instead of a general register
    function automatic logic is_mul_div(input logic [4:0] op);
        is_mul_div = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Single-source ops writing their result back to ra
    function automatic logic is_unary(input logic [4:0] op);
        is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index to one-hot select with enable
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // Enabled index lights exactly one bit; indices beyond NUM_REGS light none
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && ({28'd0, idx} == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - hardwired fetch/execute sequencer for register-ALU instructions
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int MEM_WAIT = 0,
    parameter int ALU_WAIT = 0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [31:0]         ir,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                lo_in,
    output logic                hi_in,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [4:0]          alu_opcode,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam logic [4:0] MEM_WAIT_CNT = MEM_WAIT[4:0];
    localparam logic [4:0] ALU_WAIT_CNT = ALU_WAIT[4:0];

    state_t     state;
    logic [4:0] wait_cnt;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       cls_three;
    logic       cls_mul_div;
    logic       cls_unary;
    logic       cls_legal;
    logic       unused_ir_bits;

    logic [3:0] reg_in_idx;
    logic       reg_in_en;
    logic [3:0] reg_out_idx;
    logic       reg_out_en;

    assign opcode         = ir[OPCODE_MSB:OPCODE_LSB];
    assign ra             = ir[RA_MSB:RA_LSB];
    assign rb             = ir[RB_MSB:RB_LSB];
    assign rc             = ir[RC_MSB:RC_LSB];
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    assign cls_three   = is_three_op(opcode);
    assign cls_mul_div = is_mul_div(opcode);
    assign cls_unary   = is_unary(opcode);
    assign cls_legal   = cls_three | cls_mul_div | cls_unary;

    // T-state sequencing; wait_cnt stretches T1 (memory) and mul/div T4 (ALU settle)
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_T0;
                    end
                end
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= MEM_WAIT_CNT;
                end
                S_T1: begin
                    if (wait_cnt == 5'd0) begin
                        state <= S_T2;
                    end else begin
                        wait_cnt <= wait_cnt - 5'd1;
                    end
                end
                S_T2: begin
                    state <= S_T3;
                end
                S_T3: begin
                    if (cls_legal) begin
                        state    <= S_T4;
                        wait_cnt <= ALU_WAIT_CNT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_T4: begin
                    if (cls_mul_div && (wait_cnt != 5'd0)) begin
                        wait_cnt <= wait_cnt - 5'd1;
                    end else begin
                        state <= S_T5;
                    end
                end
                S_T5: begin
                    state <= cls_mul_div ? S_T6 : S_DONE;
                end
                S_T6: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state register and the (already loaded) IR register
    always_comb begin
        pc_out      = 1'b0;
        pc_in       = 1'b0;
        inc_pc      = 1'b0;
        mar_in      = 1'b0;
        mdr_read    = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        alu_opcode  = 5'd0;
        busy        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        reg_in_idx  = 4'd0;
        reg_in_en   = 1'b0;
        reg_out_idx = 4'd0;
        reg_out_en  = 1'b0;
        case (state)
            S_T0: begin
                busy   = 1'b1;
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                busy     = 1'b1;
                zlo_out  = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                pc_in    = (wait_cnt == MEM_WAIT_CNT);
            end
            S_T2: begin
                busy    = 1'b1;
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                busy = 1'b1;
                if (cls_three) begin
                    reg_out_idx = rb;
                    reg_out_en  = 1'b1;
                    y_in        = 1'b1;
                end else if (cls_mul_div) begin
                    reg_out_idx = ra;
                    reg_out_en  = 1'b1;
                    y_in        = 1'b1;
                end else if (!cls_unary) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                busy        = 1'b1;
                alu_opcode  = opcode;
                z_in        = 1'b1;
                reg_out_idx = cls_three ? rc : rb;
                reg_out_en  = 1'b1;
            end
            S_T5: begin
                busy       = 1'b1;
                alu_opcode = opcode;
                zlo_out    = 1'b1;
                if (cls_mul_div) begin
                    lo_in = 1'b1;
                end else begin
                    reg_in_idx = ra;
                    reg_in_en  = 1'b1;
                end
            end
            S_T6: begin
                busy       = 1'b1;
                alu_opcode = opcode;
                zhi_out    = 1'b1;
                hi_in      = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_in_dec (
        .idx    (reg_in_idx),
        .en     (reg_in_en),
        .onehot (reg_in)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_out_dec (
        .idx    (reg_out_idx),
        .en     (reg_out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int MEMW = 1;
    localparam int ALUW = 2;

    localparam logic [31:0] IR_ADD = 32'h18918000;
    localparam logic [31:0] IR_DIV = 32'h83380000;
    localparam logic [31:0] IR_NOT = 32'h92280000;
    localparam logic [31:0] IR_BAD = 32'hF8000000;

    typedef struct packed {
        logic        pc_out;
        logic        pc_in;
        logic        inc_pc;
        logic        mar_in;
        logic        mdr_read;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        z_in;
        logic        zlo_out;
        logic        zhi_out;
        logic        lo_in;
        logic        hi_in;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [4:0]  alu_opcode;
        logic        busy;
        logic        done;
        logic        illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_opcode;
    logic        busy, done, illegal;

    ctl_t act;
    ctl_t exp_q[$];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   checking = 1'b0;

    alu_op_sequencer #(.NUM_REGS(16), .MEM_WAIT(MEMW), .ALU_WAIT(ALUW)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .ir         (ir),
        .pc_out     (pc_out),
        .pc_in      (pc_in),
        .inc_pc     (inc_pc),
        .mar_in     (mar_in),
        .mdr_read   (mdr_read),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .ir_in      (ir_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .zlo_out    (zlo_out),
        .zhi_out    (zhi_out),
        .lo_in      (lo_in),
        .hi_in      (hi_in),
        .reg_in     (reg_in),
        .reg_out    (reg_out),
        .alu_opcode (alu_opcode),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign act = {pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in, mdr_out, ir_in,
                  y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_in, reg_out,
                  alu_opcode, busy, done, illegal};

    // Per-cycle comparison against the model queue; an empty queue means idle (all zero)
    always @(negedge clk) begin
        ctl_t e;
        if (checking) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            nvec++;
            if (act !== e) begin
                nfail++;
                $display("FAIL outputs cycle %0d: got %h want %h", cyc, act, e);
            end
            cyc++;
        end
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] sel(input logic [3:0] i);
        logic [15:0] one;
        one = 16'd1;
        return one << i;
    endfunction

    // Model: cycle-by-cycle expected outputs of one instruction from T0 to DONE
    task automatic push_instr(input logic [31:0] w);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit three, muldiv, unary;
        ctl_t c;
        op = w[31:27]; ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
        three  = (op inside {[5'd3:5'd11]});
        muldiv = (op == 5'd15) || (op == 5'd16);
        unary  = (op == 5'd17) || (op == 5'd18);

        c = '0; c.busy = 1; c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1;
        exp_q.push_back(c);
        for (int k = 0; k <= MEMW; k++) begin
            c = '0; c.busy = 1; c.zlo_out = 1; c.mdr_read = 1; c.mdr_in = 1; c.pc_in = (k == 0);
            exp_q.push_back(c);
        end
        c = '0; c.busy = 1; c.mdr_out = 1; c.ir_in = 1;
        exp_q.push_back(c);

        c = '0; c.busy = 1;
        if (three) begin
            c.reg_out = sel(rb); c.y_in = 1;
        end else if (muldiv) begin
            c.reg_out = sel(ra); c.y_in = 1;
        end else if (!unary) begin
            c.illegal = 1;
        end
        exp_q.push_back(c);
        if (!(three || muldiv || unary)) return;

        for (int k = 0; k < (muldiv ? 1 + ALUW : 1); k++) begin
            c = '0; c.busy = 1; c.alu_opcode = op; c.z_in = 1;
            c.reg_out = three ? sel(rc) : sel(rb);
            exp_q.push_back(c);
        end
        c = '0; c.busy = 1; c.alu_opcode = op; c.zlo_out = 1;
        if (muldiv) c.lo_in = 1; else c.reg_in = sel(ra);
        exp_q.push_back(c);
        if (muldiv) begin
            c = '0; c.busy = 1; c.alu_opcode = op; c.zhi_out = 1; c.hi_in = 1;
            exp_q.push_back(c);
        end
        c = '0; c.done = 1;
        exp_q.push_back(c);
    endtask

    // Pulse start for one cycle; leaves the bench at 1ns after the edge that enters T0
    task automatic issue(input logic [31:0] w);
        @(posedge clk); #1;
        ir = w;
        start = 1'b1;
        exp_q.push_back('0);
        push_instr(w);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        lit("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start = 1'b0; ir = 32'd0;
        #12;
        lit("reset_outputs", 64'(act), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        checking = 1'b1;
        repeat (5) @(posedge clk);
        #3; clr = 1'b1; #1;
        lit("midclock_clr_outputs", 64'(act), 64'd0);
        @(posedge clk); #1; clr = 1'b0;

        // ADD R1,R2,R3
        issue(IR_ADD);
        repeat (4) @(posedge clk);
        @(negedge clk); lit("add_t3_reg_out", 64'(reg_out), 64'h0004);
        @(negedge clk); lit("add_t4_reg_out", 64'(reg_out), 64'h0008);
                        lit("add_t4_alu_opcode", 64'(alu_opcode), 64'h03);
        @(negedge clk); lit("add_t5_reg_in", 64'(reg_in), 64'h0002);
        @(negedge clk); lit("add_done", 64'(done), 64'd1);
        drain();

        // DIV R6,R7 with ALU_WAIT=2
        issue(IR_DIV);
        repeat (4) @(posedge clk);
        @(negedge clk); lit("div_t3_reg_out", 64'(reg_out), 64'h0040);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("div_t4_reg_out", 64'(reg_out), 64'h0080);
            lit("div_t4_alu_opcode", 64'(alu_opcode), 64'h10);
        end
        @(negedge clk); lit("div_t5_lo_in", 64'(lo_in), 64'd1);
        @(negedge clk); lit("div_t6_hi_in", 64'(hi_in), 64'd1);
        @(negedge clk); lit("div_done", 64'(done), 64'd1);
        drain();

        // NOT R4,R5 with MEM_WAIT=1
        issue(IR_NOT);
        @(negedge clk); lit("not_t0_pc_in", 64'(pc_in), 64'd0);
        @(negedge clk); lit("not_t1a_pc_in", 64'(pc_in), 64'd1);
        @(negedge clk); lit("not_t1b_pc_in", 64'(pc_in), 64'd0);
                        lit("not_t1b_mdr_read", 64'(mdr_read), 64'd1);
        @(negedge clk);
        @(negedge clk); lit("not_t3_quiet", 64'({reg_out, y_in, z_in}), 64'd0);
        @(negedge clk); lit("not_t4_reg_out", 64'(reg_out), 64'h0020);
        @(negedge clk); lit("not_t5_reg_in", 64'(reg_in), 64'h0010);
        drain();

        // Undefined opcode, then a normal instruction
        issue(IR_BAD);
        repeat (4) @(posedge clk);
        @(negedge clk); lit("bad_t3_illegal", 64'(illegal), 64'd1);
        @(negedge clk); lit("bad_after_idle", 64'({illegal, busy, done, reg_in}), 64'd0);
        drain();
        issue(IR_ADD);
        drain();

        // Abort DIV in T4: outputs drop at once and no HI/LO load follows
        issue(IR_DIV);
        repeat (5) @(posedge clk);
        #2; clr = 1'b1; exp_q.delete(); #1;
        lit("abort_outputs", 64'(act), 64'd0);
        @(posedge clk); #1; clr = 1'b0;
        repeat (8) @(posedge clk);

        // start held high across a whole ADD: second instruction only after DONE->IDLE
        @(posedge clk); #1;
        ir = IR_ADD;
        start = 1'b1;
        exp_q.push_back('0);
        push_instr(IR_ADD);
        exp_q.push_back('0);
        push_instr(IR_ADD);
        repeat (10) @(posedge clk);
        #1; start = 1'b0;
        drain();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
